// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - shared encodings for the LEGv8 multicycle sequencer
package legv8_ctrl_pkg;

   // Sequencer states; values are visible on the debug state port
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_t;

   // Instruction classes latched in DECODE
   typedef enum logic [3:0] {
      C_NOP     = 4'd0,
      C_AND     = 4'd1,
      C_ORR     = 4'd2,
      C_ADD     = 4'd3,
      C_SUB     = 4'd4,
      C_ADDI    = 4'd5,
      C_SUBI    = 4'd6,
      C_MOVZ    = 4'd7,
      C_B       = 4'd8,
      C_CBZ     = 4'd9,
      C_LDUR    = 4'd10,
      C_STUR    = 4'd11,
      C_ILLEGAL = 4'd15
   } opclass_t;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [1:0] SIGN_IMM12 = 2'b00;
   localparam logic [1:0] SIGN_D9    = 2'b01;
   localparam logic [1:0] SIGN_B26   = 2'b10;
   localparam logic [1:0] SIGN_CB19  = 2'b11;

   // Opcode patterns as value/care-mask pairs (mask 0 = don't care bit)
   localparam logic [10:0] OP_AND_V  = 11'b10001010000, OP_AND_M  = 11'b11111111111;
   localparam logic [10:0] OP_ORR_V  = 11'b10101010000, OP_ORR_M  = 11'b11111111111;
   localparam logic [10:0] OP_ADD_V  = 11'b10001011000, OP_ADD_M  = 11'b11111111111;
   localparam logic [10:0] OP_SUB_V  = 11'b11001011000, OP_SUB_M  = 11'b11111111111;
   localparam logic [10:0] OP_ADDI_V = 11'b10010001000, OP_ADDI_M = 11'b11111111110;
   localparam logic [10:0] OP_SUBI_V = 11'b11010001000, OP_SUBI_M = 11'b11111111110;
   localparam logic [10:0] OP_MOVZ_V = 11'b11010010100, OP_MOVZ_M = 11'b11111111100;
   localparam logic [10:0] OP_B_V    = 11'b00010100000, OP_B_M    = 11'b11111100000;
   localparam logic [10:0] OP_CBZ_V  = 11'b10110100000, OP_CBZ_M  = 11'b11111111000;
   localparam logic [10:0] OP_LDUR_V = 11'b11111000010, OP_LDUR_M = 11'b11111111111;
   localparam logic [10:0] OP_STUR_V = 11'b11111000000, OP_STUR_M = 11'b11111111111;

   // True when every cared-about bit of op equals the pattern
   function automatic logic op_match(input logic [10:0] op, input logic [10:0] val,
                                     input logic [10:0] mask);
      return ((op ^ val) & mask) == 11'd0;
   endfunction

endpackage

// File: rtl/legv8_opclass_decode.sv
// rtl/legv8_opclass_decode.sv - combinational 11-bit opcode to instruction class
module legv8_opclass_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0] opcode,
   output opclass_t    op_class
);

   // Patterns do not overlap, so priority order is irrelevant
   always_comb begin
      op_class = C_ILLEGAL;
      if      (op_match(opcode, OP_AND_V,  OP_AND_M))  op_class = C_AND;
      else if (op_match(opcode, OP_ORR_V,  OP_ORR_M))  op_class = C_ORR;
      else if (op_match(opcode, OP_ADD_V,  OP_ADD_M))  op_class = C_ADD;
      else if (op_match(opcode, OP_SUB_V,  OP_SUB_M))  op_class = C_SUB;
      else if (op_match(opcode, OP_ADDI_V, OP_ADDI_M)) op_class = C_ADDI;
      else if (op_match(opcode, OP_SUBI_V, OP_SUBI_M)) op_class = C_SUBI;
      else if (op_match(opcode, OP_MOVZ_V, OP_MOVZ_M)) op_class = C_MOVZ;
      else if (op_match(opcode, OP_B_V,    OP_B_M))    op_class = C_B;
      else if (op_match(opcode, OP_CBZ_V,  OP_CBZ_M))  op_class = C_CBZ;
      else if (op_match(opcode, OP_LDUR_V, OP_LDUR_M)) op_class = C_LDUR;
      else if (op_match(opcode, OP_STUR_V, OP_STUR_M)) op_class = C_STUR;
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - LEGv8 multicycle sequencer; MULTICYCLE_PERF_EN adds perf counters
module multicycle_control
   import legv8_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
)(
   input  logic        CLK,
   input  logic        Reset,
   input  logic [10:0] opcode,
   input  logic        alu_zero,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_read,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg2loc,
   output logic        alusrc,
   output logic        mem2reg,
   output logic        regwrite,
   output logic        memread,
   output logic        memwrite,
   output logic [3:0]  aluop,
   output logic [1:0]  signop,
   output logic [2:0]  state,
   output logic        illegal,
   output logic        fault
`ifdef MULTICYCLE_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
`endif
);

   // Last wait count before a stalled handshake is declared dead
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state_q, state_d;
   opclass_t   class_q, class_d;
   opclass_t   dec_class;
   logic [7:0] wait_q, wait_d;
   logic       fault_q, fault_d;

   // ALU-side controls implied by the latched class
   logic [3:0] cls_aluop;
   logic [1:0] cls_signop;
   logic       cls_alusrc;

   legv8_opclass_decode u_decode (
      .opcode   (opcode),
      .op_class (dec_class)
   );

   // State, class, wait counter and sticky fault registers
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= S_FETCH;
         class_q <= C_NOP;
         wait_q  <= 8'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end

   // Next state; the wait counter only runs while parked on a handshake
   always_comb begin
      state_d = state_q;
      class_d = class_q;
      fault_d = fault_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready)              state_d = S_DECODE;
            else if (wait_q >= WAIT_LAST) state_d = S_FAULT;
         end
         S_DECODE: begin
            if (dec_class == C_ILLEGAL) begin
               class_d = C_NOP;
               state_d = S_FETCH;
            end else begin
               class_d = dec_class;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (class_q)
               C_LDUR, C_STUR:   state_d = S_MEM;
               C_B, C_CBZ, C_NOP: state_d = S_FETCH;
               default:          state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ready)              state_d = (class_q == C_LDUR) ? S_WB : S_FETCH;
            else if (wait_q >= WAIT_LAST) state_d = S_FAULT;
         end
         S_WB:    state_d = S_FETCH;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FETCH;
      endcase
      if (state_d == S_FAULT) fault_d = 1'b1;
      if (state_d != state_q)
         wait_d = 8'd0;
      else if (state_q == S_FETCH || state_q == S_MEM)
         wait_d = wait_q + 8'd1;
      else
         wait_d = wait_q;
   end

   // ALU operation, operand source and immediate format per class
   always_comb begin
      cls_aluop  = 4'b0000;
      cls_signop = SIGN_IMM12;
      cls_alusrc = 1'b0;
      case (class_q)
         C_AND:  cls_aluop = ALU_AND;
         C_ORR:  cls_aluop = ALU_ORR;
         C_ADD:  cls_aluop = ALU_ADD;
         C_SUB:  cls_aluop = ALU_SUB;
         C_ADDI: begin cls_aluop = ALU_ADD;   cls_alusrc = 1'b1; end
         C_SUBI: begin cls_aluop = ALU_SUB;   cls_alusrc = 1'b1; end
         // MOVZ passes the zero-extended wide immediate straight through
         C_MOVZ: begin cls_aluop = ALU_PASSB; cls_alusrc = 1'b1; end
         C_B:    cls_signop = SIGN_B26;
         // CBZ passes Rt through so alu_zero reflects the tested register
         C_CBZ:  begin cls_aluop = ALU_PASSB; cls_signop = SIGN_CB19; end
         C_LDUR, C_STUR: begin
            cls_aluop  = ALU_ADD;
            cls_alusrc = 1'b1;
            cls_signop = SIGN_D9;
         end
         default: ;
      endcase
   end

   // Datapath controls; everything is held low while Reset is asserted
   always_comb begin
      imem_read = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg2loc   = 1'b0;
      alusrc    = 1'b0;
      mem2reg   = 1'b0;
      regwrite  = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      aluop     = 4'b0000;
      signop    = 2'b00;
      illegal   = 1'b0;
      if (!Reset) begin
         case (state_q)
            S_FETCH: begin
               imem_read = 1'b1;
               ir_write  = imem_ready;
               pc_write  = imem_ready;
            end
            S_DECODE: illegal = (dec_class == C_ILLEGAL);
            S_EXEC: begin
               aluop  = cls_aluop;
               alusrc = cls_alusrc;
               signop = cls_signop;
               if (class_q == C_B) begin
                  pc_write = 1'b1;
                  pc_src   = 1'b1;
               end
               if (class_q == C_CBZ) begin
                  reg2loc  = 1'b1;
                  pc_write = alu_zero;
                  pc_src   = 1'b1;
               end
               if (class_q == C_STUR) reg2loc = 1'b1;
            end
            // Address stays on the ALU for the whole memory access
            S_MEM: begin
               aluop    = cls_aluop;
               alusrc   = cls_alusrc;
               signop   = cls_signop;
               memread  = (class_q == C_LDUR);
               memwrite = (class_q == C_STUR);
               reg2loc  = (class_q == C_STUR);
            end
            // Without a result register the ALU must keep driving the write data
            S_WB: begin
               regwrite = 1'b1;
               if (class_q == C_LDUR) begin
                  mem2reg = 1'b1;
               end else begin
                  aluop  = cls_aluop;
                  alusrc = cls_alusrc;
                  signop = cls_signop;
               end
            end
            default: ;
         endcase
      end
   end

   assign state = state_q;
   assign fault = fault_q;

`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] instr_q, instr_d;

   // Retired-instruction and active-cycle counters, both wrapping
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         cycle_q <= 32'd0;
         instr_q <= 32'd0;
      end else begin
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   // An instruction retires on any return to FETCH after EXEC
   always_comb begin
      cycle_d = (state_q != S_FAULT) ? cycle_q + 32'd1 : cycle_q;
      instr_d = instr_q;
      if (state_d == S_FETCH &&
          (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
         instr_d = instr_q + 32'd1;
   end

   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

   logic        CLK;
   logic        Reset;
   logic [10:0] opcode;
   logic        alu_zero, imem_ready, dmem_ready;
   logic        imem_read, ir_write, pc_write, pc_src, reg2loc, alusrc;
   logic        mem2reg, regwrite, memread, memwrite, illegal, fault;
   logic [3:0]  aluop;
   logic [1:0]  signop;
   logic [2:0]  state;
`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_stray_regw = 0;

   multicycle_control #(.TIMEOUT_CYCLES(16)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .opcode     (opcode),
      .alu_zero   (alu_zero),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_read  (imem_read),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg2loc    (reg2loc),
      .alusrc     (alusrc),
      .mem2reg    (mem2reg),
      .regwrite   (regwrite),
      .memread    (memread),
      .memwrite   (memwrite),
      .aluop      (aluop),
      .signop     (signop),
      .state      (state),
      .illegal    (illegal),
      .fault      (fault)
`ifdef MULTICYCLE_PERF_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .instr_cnt  (instr_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      tick();
      Reset = 1'b0;
   endtask

   // Runs one instruction from FETCH back to FETCH, tallying control activity
   task automatic run_instr(input logic [10:0] opc, input logic zero, input int mem_wait,
                            output int cyc, output int n_memr, output int n_memw,
                            output int n_regw, output int n_pcw, output int n_ill);
      int mem_n = 0;
      cyc = 0; n_memr = 0; n_memw = 0; n_regw = 0; n_pcw = 0; n_ill = 0;
      opcode = opc;
      alu_zero = zero;
      imem_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         dmem_ready = (state == 3'd3) && (mem_n >= mem_wait);
         #1;
         n_memr += int'(memread);
         n_memw += int'(memwrite);
         n_regw += int'(regwrite);
         n_pcw  += int'(pc_write);
         n_ill  += int'(illegal);
         if (regwrite && state != 3'd4) n_stray_regw++;
         if (state == 3'd3) mem_n++;
         cyc++;
         tick();
         if (state == 3'd0) break;
      end
      dmem_ready = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input logic [10:0] opc, input logic zero,
                                input int mem_wait, input int e_cyc, input int e_memr,
                                input int e_memw, input int e_regw, input int e_pcw,
                                input int e_ill);
      int cyc, memr, memw, regw, pcw, ill;
      run_instr(opc, zero, mem_wait, cyc, memr, memw, regw, pcw, ill);
      check({tag, "_cycles"},   cyc,  e_cyc);
      check({tag, "_memread"},  memr, e_memr);
      check({tag, "_memwrite"}, memw, e_memw);
      check({tag, "_regwrite"}, regw, e_regw);
      check({tag, "_pcwrite"},  pcw,  e_pcw);
      check({tag, "_illegal"},  ill,  e_ill);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b1;
      opcode = 11'd0;
      alu_zero = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_state", state, 3'd0);
      check("rst_fault", fault, 1'b0);
      check("rst_imem_read", imem_read, 1'b0);
      check("rst_pc_write", pc_write, 1'b0);
`ifdef MULTICYCLE_PERF_EN
      check("rst_cycle_cnt", cycle_cnt, 32'd0);
      check("rst_instr_cnt", instr_cnt, 32'd0);
`endif
      Reset = 1'b0;

      // ADD walked state by state
      opcode = 11'b10001011000;
      imem_ready = 1'b1;
      #1;
      check("add_f_state", state, 3'd0);
      check("add_f_ir_write", ir_write, 1'b1);
      check("add_f_pc_write", pc_write, 1'b1);
      check("add_f_pc_src", pc_src, 1'b0);
      check("add_f_regwrite", regwrite, 1'b0);
      tick();
      imem_ready = 1'b0;
      #1;
      check("add_d_state", state, 3'd1);
      check("add_d_regwrite", regwrite, 1'b0);
      check("add_d_illegal", illegal, 1'b0);
      tick();
      check("add_e_state", state, 3'd2);
      check("add_e_aluop", aluop, 4'b0010);
      check("add_e_alusrc", alusrc, 1'b0);
      check("add_e_regwrite", regwrite, 1'b0);
      tick();
      check("add_w_state", state, 3'd4);
      check("add_w_regwrite", regwrite, 1'b1);
      check("add_w_mem2reg", mem2reg, 1'b0);
      tick();
      check("add_back_state", state, 3'd0);

      // CBZ EXEC controls
      opcode = 11'b10110100101;
      imem_ready = 1'b1;
      alu_zero = 1'b1;
      tick();
      tick();
      check("cbz_e_state", state, 3'd2);
      check("cbz_e_pc_write", pc_write, 1'b1);
      check("cbz_e_pc_src", pc_src, 1'b1);
      check("cbz_e_reg2loc", reg2loc, 1'b1);
      check("cbz_e_signop", signop, 2'b11);
      alu_zero = 1'b0;
      #1;
      check("cbz_e_nz_pc_write", pc_write, 1'b0);
      tick();
      check("cbz_back_state", state, 3'd0);

      //            tag       opcode          z   wait cyc memr memw regw pcw ill
      run_and_check("add",    11'b10001011000, 0, 0,   4,  0,   0,   1,   1,  0);
      run_and_check("and",    11'b10001010000, 0, 0,   4,  0,   0,   1,   1,  0);
      run_and_check("orr",    11'b10101010000, 0, 0,   4,  0,   0,   1,   1,  0);
      run_and_check("subi",   11'b11010001001, 0, 0,   4,  0,   0,   1,   1,  0);
      run_and_check("movz",   11'b11010010111, 0, 0,   4,  0,   0,   1,   1,  0);
      run_and_check("b",      11'b00010111111, 0, 0,   3,  0,   0,   0,   2,  0);
      run_and_check("cbz_z1", 11'b10110100000, 1, 0,   3,  0,   0,   0,   2,  0);
      run_and_check("cbz_z0", 11'b10110100000, 0, 0,   3,  0,   0,   0,   1,  0);
      run_and_check("ldur",   11'b11111000010, 0, 0,   5,  1,   0,   1,   1,  0);
      run_and_check("ldur_w3",11'b11111000010, 0, 3,   8,  4,   0,   1,   1,  0);
      run_and_check("stur",   11'b11111000000, 0, 0,   4,  0,   1,   0,   1,  0);
      run_and_check("stur_w2",11'b11111000000, 0, 2,   6,  0,   3,   0,   1,  0);
      run_and_check("illeg",  11'b00000000000, 0, 0,   2,  0,   0,   0,   1,  1);
      check("regwrite_outside_wb", n_stray_regw, 0);

      // Fetch stalled 15 cycles is still legal
      do_reset();
      repeat (15) tick();
      check("wait15_state", state, 3'd0);
      check("wait15_fault", fault, 1'b0);
      imem_ready = 1'b1;
      tick();
      check("wait15_decode", state, 3'd1);

      // Fetch stalled 16 cycles faults
      do_reset();
      repeat (15) tick();
      check("to_pre_state", state, 3'd0);
      tick();
      check("to_state", state, 3'd7);
      check("to_fault", fault, 1'b1);
      check("to_imem_read", imem_read, 1'b0);
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      tick();
      check("to_stuck_state", state, 3'd7);
      check("to_stuck_ir_write", ir_write, 1'b0);
      check("to_stuck_fault", fault, 1'b1);

      // Reset during STUR memory phase
      do_reset();
      check("rst_clears_fault", fault, 1'b0);
      opcode = 11'b11111000000;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      repeat (3) tick();
      check("stur_mem_state", state, 3'd3);
      check("stur_mem_memwrite", memwrite, 1'b1);
      check("stur_mem_reg2loc", reg2loc, 1'b1);
      Reset = 1'b1;
      #1;
      check("stur_rst_memwrite", memwrite, 1'b0);
      check("stur_rst_state", state, 3'd0);
`ifdef MULTICYCLE_PERF_EN
      check("stur_rst_cycle_cnt", cycle_cnt, 32'd0);
      check("stur_rst_instr_cnt", instr_cnt, 32'd0);
`endif
      tick();
      Reset = 1'b0;
      #1;
      check("stur_rel_state", state, 3'd0);
      check("stur_rel_memwrite", memwrite, 1'b0);
      tick();
      check("stur_rel_next", state, 3'd1);
      check("stur_rel_next_memwrite", memwrite, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
